fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 16-bit pipelined core: owns the program counter.
//   Presents the PC combinationally to instruction memory and captures the returned word.
//   Stores that word, with its PC, in the IF/ID pipeline register that decode consumes.
//   Handles pipeline stall, branch/jump redirect with bubble insertion, and halt on fetching past the end of instruction memory.
// PARAMETERS
//   RESET_PC    16'h0000  PC loaded on reset
//   IMEM_DEPTH  16        number of valid instruction words; fetch at PC >= IMEM_DEPTH halts
// PORTS
//   clk             in   1   clock, all state updates on rising edge
//   rst             in   1   synchronous reset, active-high
//   stall           in   1   hazard unit: hold PC and IF/ID this cycle
//   redirect        in   1   branch/jump taken, from EX
//   redirect_pc     in   16  new PC when redirect=1
//   imem_pc         out  16  address to instruction memory (= pc_q, combinational)
//   imem_instr      in   16  instruction word from memory (combinational read)
//   if_id_instr     out  16  latched instruction for decode
//   if_id_pc        out  16  PC of if_id_instr
//   if_id_pc_plus1  out  16  if_id_pc + 1, for branch-offset/link arithmetic
//   if_id_valid     out  1   if_id_* hold a real instruction (0 = bubble)
//   halted          out  1   1 while FSM is in HALT
//   fetch_count     out  16  instructions latched since reset, saturates at 16'hFFFF
// BEHAVIOUR
//   - State: pc_q, IF/ID regs, FSM {RUN, HALT}, fetch_count. No async logic; imem_pc = pc_q.
//   - PC is a word address: increment by 1. All PC arithmetic is mod 2^16 (FFFF+1 -> 0000).
//   - Latency: the word at PC p appears on if_id_instr one clock after pc_q = p.
//   - Per-edge priority: rst > redirect > stall > FSM step.
//   - rst: pc_q=RESET_PC; if_id_instr=0; if_id_pc=0; if_id_pc_plus1=0; if_id_valid=0; fetch_count=0; state=RUN.
//     Reset mid-operation discards everything in flight. halted=0 in the cycle after reset.
//   - redirect (any state, also when stall=1):
//     pc_q<=redirect_pc; if_id_valid<=0; if_id_instr<=16'h0000 (bubble).
//     Next state is RUN if redirect_pc < IMEM_DEPTH, else HALT. fetch_count unchanged.
//   - stall, no redirect: pc_q, IF/ID regs, state and fetch_count all hold.
//   - RUN, pc_q < IMEM_DEPTH:
//     if_id_instr<=imem_instr; if_id_pc<=pc_q; if_id_pc_plus1<=pc_q+1; if_id_valid<=1.
//     pc_q<=pc_q+1; fetch_count<=sat(fetch_count+1).
//   - RUN, pc_q >= IMEM_DEPTH: state<=HALT; if_id_valid<=0; if_id_instr<=0; pc_q holds; no count.
//   - HALT: pc_q and count hold; if_id_valid=0; halted=1. Exit only via rst or redirect.
//   - Instruction 16'h0000 is a legal NOP. It is latched with valid=1 like any other word.
//     Only address range decides halting, never instruction content.
//   - fetch_count at 16'hFFFF stays 16'hFFFF.
// STRUCTURE
//   - cpu_pkg: DATA_W=16, ADDR_W=16, NOP_INSTR=16'h0000, fetch FSM state localparams (RUN, HALT).
//   - One sub-module: if_id_reg.
//     Holds instr/pc/pc_plus1/valid; inputs load, flush, hold; flush has priority over hold.
//   - PC register, next-PC mux, FSM and counter stay in fetch_stage.
// TESTING
//   - Reset with memory holding 444f,465f,14c0 at 0..2, run 3 clocks:
//     if_id_instr = 444f/465f/14c0, if_id_pc = 0/1/2, valid=1, fetch_count=3.
//   - stall=1 for 2 cycles at pc_q=4: imem_pc stays 4, if_id_* unchanged.
//     After release, next capture is pc 4.
//   - redirect=1, redirect_pc=1 at pc_q=5: next cycle valid=0, instr=0000, imem_pc=1.
//     Following cycle if_id_pc=1, instr=465f.
//   - IMEM_DEPTH=16, free-run from 0: after if_id_pc=15, next edge halted=1, valid=0.
//     imem_pc holds 16; fetch_count=16 and stays.
//   - redirect and stall both 1, redirect_pc=3: redirect wins, imem_pc=3, valid=0.
//     redirect_pc=20 while in RUN: halted=1 next cycle.
//   - rst asserted mid-run with valid=1 and fetch_count=7:
//     next cycle imem_pc=RESET_PC, valid=0, fetch_count=0, halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants, fetch FSM state type and small helpers for the 16-bit core.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Saturating increment: an all-ones value stays pinned.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched word and its PC for decode.
// A flush turns the slot into a bubble and takes priority over hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus1,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pcPlus1;
  logic              r_valid;

  // A flush only clears instr/valid; the PC fields keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= NOP_INSTR;
      r_pc      <= '0;
      r_pcPlus1 <= '0;
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold && i_load) begin
      r_instr   <= i_instr;
      r_pc      <= i_pc;
      r_pcPlus1 <= i_pc + 16'd1;
      r_valid   <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus1 = r_pcPlus1;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills IF/ID.
// Handles stall, redirect (with bubble) and halting on fetch past the end of memory.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          IMEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instr,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  // One extra bit so a depth of 65536 still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(IMEM_DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_stateNext;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pcNext;
  logic [15:0]       r_count;

  logic w_inRange;
  logic w_redirectInRange;
  logic w_step;
  logic w_load;
  logic w_flush;

  assign w_inRange         = {1'b0, r_pc} < DEPTH_W;
  assign w_redirectInRange = {1'b0, redirect_pc} < DEPTH_W;
  assign w_step            = !redirect && !stall && (r_state == RUN);
  assign w_load            = w_step && w_inRange;
  assign w_flush           = redirect || (w_step && !w_inRange);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (w_load) begin
        r_count <= sat_inc(r_count);
      end
    end
  end

  // Redirect beats stall; running off the end of memory halts with the PC parked.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    if (redirect) begin
      w_pcNext    = redirect_pc;
      w_stateNext = w_redirectInRange ? RUN : HALT;
    end else if (w_load) begin
      w_pcNext = r_pc + 16'd1;
    end else if (w_step) begin
      w_stateNext = HALT;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_hold     (stall),
    .i_instr    (imem_instr),
    .i_pc       (r_pc),
    .o_instr    (if_id_instr),
    .o_pc       (if_id_pc),
    .o_pc_plus1 (if_id_pc_plus1),
    .o_valid    (if_id_valid)
  );

  assign imem_pc     = r_pc;
  assign halted      = (r_state == HALT);
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, all checked against a cycle-level reference model.
module tb_fetch_stage;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_pc, imem_instr;
  logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus1, fetch_count;
  logic        if_id_valid, halted;

  logic [15:0] mem [256];

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model of architectural state.
  logic [15:0] mPc, mInstr, mIfPc, mIfPp1, mCount;
  logic        mValid, mHalted;

  fetch_stage #(.RESET_PC(16'h0000), .IMEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc[7:0]];

  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".imem_pc"}, imem_pc, mPc);
    checkValue({tag, ".instr"}, if_id_instr, mInstr);
    checkValue({tag, ".pc"}, if_id_pc, mIfPc);
    checkValue({tag, ".pc_plus1"}, if_id_pc_plus1, mIfPp1);
    checkValue({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, mValid});
    checkValue({tag, ".halted"}, {15'd0, halted}, {15'd0, mHalted});
    checkValue({tag, ".count"}, fetch_count, mCount);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic rd,
                               input logic [15:0] rp, input string tag);
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
    if (r) begin
      mPc = 16'h0000; mInstr = 16'h0000; mIfPc = 16'h0000; mIfPp1 = 16'h0000;
      mValid = 1'b0; mCount = 16'h0000; mHalted = 1'b0;
    end else if (rd) begin
      mPc = rp; mValid = 1'b0; mInstr = 16'h0000;
      mHalted = (int'(rp) >= DEPTH);
    end else if (!s && !mHalted) begin
      if (int'(mPc) < DEPTH) begin
        mInstr = mem[mPc[7:0]]; mIfPc = mPc; mIfPp1 = mPc + 16'd1; mValid = 1'b1;
        mPc = mPc + 16'd1;
        if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
      end else begin
        mHalted = 1'b1; mValid = 1'b0; mInstr = 16'h0000;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = (i % 5 == 4) ? 16'h0000 : 16'($urandom);
    mem[0] = 16'h444f; mem[1] = 16'h465f; mem[2] = 16'h14c0;

    // Reset, then the first three fetches.
    applyStimulus(1, 0, 0, 0, "reset");
    checkValue("reset_count", fetch_count, 16'd0);
    applyStimulus(0, 0, 0, 0, "f0");
    checkValue("f0_instr", if_id_instr, 16'h444f);
    applyStimulus(0, 0, 0, 0, "f1");
    checkValue("f1_instr", if_id_instr, 16'h465f);
    applyStimulus(0, 0, 0, 0, "f2");
    checkValue("f2_instr", if_id_instr, 16'h14c0);
    checkValue("f2_count", fetch_count, 16'd3);
    applyStimulus(0, 0, 0, 0, "f3");

    // Stall two cycles at pc 4, then release.
    applyStimulus(0, 1, 0, 0, "stall0");
    applyStimulus(0, 1, 0, 0, "stall1");
    checkValue("stall_pc", imem_pc, 16'd4);
    checkValue("stall_ifpc", if_id_pc, 16'd3);
    applyStimulus(0, 0, 0, 0, "release");
    checkValue("release_ifpc", if_id_pc, 16'd4);

    // Redirect back to 1 from pc 5.
    applyStimulus(0, 0, 1, 16'd1, "redir");
    checkValue("redir_valid", {15'd0, if_id_valid}, 16'd0);
    checkValue("redir_imem", imem_pc, 16'd1);
    applyStimulus(0, 0, 0, 0, "redir_next");
    checkValue("redir_instr", if_id_instr, 16'h465f);

    // Free-run from reset until the end of memory.
    applyStimulus(1, 0, 0, 0, "reset2");
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, "run");
    checkValue("last_ifpc", if_id_pc, 16'd15);
    applyStimulus(0, 0, 0, 0, "halt");
    checkValue("halt_flag", {15'd0, halted}, 16'd1);
    checkValue("halt_imem", imem_pc, 16'd16);
    applyStimulus(0, 0, 0, 0, "halt_hold");
    checkValue("halt_count", fetch_count, 16'd16);

    // Redirect wins over stall and leaves HALT; out-of-range redirect halts.
    applyStimulus(0, 1, 1, 16'd3, "redir_stall");
    checkValue("rs_imem", imem_pc, 16'd3);
    checkValue("rs_halted", {15'd0, halted}, 16'd0);
    applyStimulus(0, 0, 0, 0, "rs_run");
    applyStimulus(0, 0, 1, 16'd20, "redir_far");
    checkValue("far_halted", {15'd0, halted}, 16'd1);

    // Reset mid-run discards in-flight state.
    applyStimulus(1, 0, 0, 0, "reset3");
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, "pre");
    checkValue("pre_count", fetch_count, 16'd7);
    applyStimulus(1, 0, 0, 0, "midreset");
    checkValue("mid_imem", imem_pc, 16'd0);
    checkValue("mid_count", fetch_count, 16'd0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 20)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
